// File: rtl/ysyx_22041207_lsu.sv
// ---------------------------------------------------------------------------
// ysyx_22041207_lsu
// Load/store unit for the RV64 core. It takes the ALU-computed address, the
// rs2 store data and the decoder's memory descriptor (read enable, byte count,
// sign-extend flag, write mask). It runs the access on a 64-bit, 8-byte-aligned
// data bus and returns aligned, extended load data to writeback. An access that
// crosses an 8-byte boundary is split into two bus beats.
//
// Ports
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   req_*            request channel (valid/ready), latched on accept
//   resp_valid       one-cycle completion pulse
//   resp_rdata/err   result and malformed-request flag, held until next completion
//   mem_valid/ready  bus request handshake; addr/wen/wdata/wstrb describe the beat
//   mem_rvalid/rdata read data return, may arrive with or after mem_ready
// ---------------------------------------------------------------------------
module ysyx_22041207_lsu #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [7:0]        req_wmask,
    input  logic              req_ren,
    input  logic [3:0]        req_rnum,
    input  logic              req_sext,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_wstrb,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        BEAT0,
        WAIT0,
        BEAT1,
        WAIT1,
        DONE
    } state_t;

    state_t state;

    // Request fields latched on accept.
    logic              ren_q;
    logic              sext_q;
    logic              two_beat_q;
    logic [3:0]        size_q;
    logic [2:0]        off_q;
    logic [ADDR_W-1:0] base_q;
    logic [DATA_W-1:0] wdata_q;
    logic [7:0]        wmask_q;

    // Read buffer halves: buf0 from the first beat, buf1 from the second.
    logic [DATA_W-1:0] buf0;
    logic [DATA_W-1:0] buf1;

    // Request decode, evaluated on the incoming request.
    logic [3:0]          req_size;
    logic                req_bad;
    logic                req_null;
    logic                req_two;
    logic [ADDR_W-1:0]   req_base;
    logic [2*DATA_W-1:0] req_lane_data;
    logic [15:0]         req_lane_strb;

    // Second-beat lanes come from the latched request.
    logic [2*DATA_W-1:0] q_lane_data;
    logic [15:0]         q_lane_strb;

    // Beat progress.
    logic in_beat;
    logic in_wait;
    logic beat_done;
    logic go_wait;
    logic cap0;
    logic cap1;

    // Load result path.
    logic [DATA_W-1:0]   buf0_n;
    logic [DATA_W-1:0]   buf1_n;
    logic [2*DATA_W-1:0] joined;
    logic [DATA_W-1:0]   load_data;

    // A load carries its size in rnum and must not also carry a write mask;
    // a store derives its size from the mask, and only the four contiguous
    // masks are legal. rnum is ignored for stores.
    always_comb begin
        req_size = 4'd0;
        req_bad  = 1'b0;
        if (req_ren) begin
            if (req_wmask != 8'h00) begin
                req_bad = 1'b1;
            end
            case (req_rnum)
                4'd1, 4'd2, 4'd4, 4'd8: req_size = req_rnum;
                default:                req_bad  = 1'b1;
            endcase
        end else begin
            case (req_wmask)
                8'h00:   req_size = 4'd0;
                8'h01:   req_size = 4'd1;
                8'h03:   req_size = 4'd2;
                8'h0F:   req_size = 4'd4;
                8'hFF:   req_size = 4'd8;
                default: req_bad  = 1'b1;
            endcase
        end
    end

    assign req_null      = !req_ren && (req_wmask == 8'h00);
    assign req_base      = {req_addr[ADDR_W-1:3], 3'b000};
    assign req_two       = ({1'b0, req_addr[2:0]} + req_size) > 4'd8;
    assign req_lane_data = {{DATA_W{1'b0}}, req_wdata} << {req_addr[2:0], 3'b000};
    assign req_lane_strb = {8'h00, req_wmask} << req_addr[2:0];
    assign q_lane_data   = {{DATA_W{1'b0}}, wdata_q} << {off_q, 3'b000};
    assign q_lane_strb   = {8'h00, wmask_q} << off_q;

    // A write beat finishes on mem_ready. A read beat finishes when its data
    // arrives, either together with mem_ready or later in the WAIT state.
    assign in_beat   = (state == BEAT0) || (state == BEAT1);
    assign in_wait   = (state == WAIT0) || (state == WAIT1);
    assign beat_done = (in_beat && mem_ready && (!ren_q || mem_rvalid)) ||
                       (in_wait && mem_rvalid);
    assign go_wait   = in_beat && mem_ready && ren_q && !mem_rvalid;
    assign cap0      = ren_q && beat_done && ((state == BEAT0) || (state == WAIT0));
    assign cap1      = ren_q && beat_done && ((state == BEAT1) || (state == WAIT1));

    // The load result is formed from the buffer contents as they will be after
    // this cycle's capture, so the result can be registered on the same edge
    // that completes the last beat.
    always_comb begin
        buf0_n = cap0 ? mem_rdata : buf0;
        buf1_n = cap1 ? mem_rdata : buf1;
        joined = {buf1_n, buf0_n} >> {off_q, 3'b000};
        case (size_q)
            4'd1:    load_data = sext_q ? {{56{joined[7]}},  joined[7:0]}  : {56'd0, joined[7:0]};
            4'd2:    load_data = sext_q ? {{48{joined[15]}}, joined[15:0]} : {48'd0, joined[15:0]};
            4'd4:    load_data = sext_q ? {{32{joined[31]}}, joined[31:0]} : {32'd0, joined[31:0]};
            default: load_data = joined[DATA_W-1:0];
        endcase
    end

    // Control FSM with registered outputs. The bus beat is described by
    // registers that are loaded on the edge entering BEAT0/BEAT1 and left
    // untouched until the beat handshakes, which keeps addr/data/strb stable
    // under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_valid  <= 1'b0;
            mem_wen    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= 8'h00;
            ren_q      <= 1'b0;
            sext_q     <= 1'b0;
            two_beat_q <= 1'b0;
            size_q     <= 4'd0;
            off_q      <= 3'd0;
            base_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= 8'h00;
            buf0       <= '0;
            buf1       <= '0;
        end else begin
            resp_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        ren_q      <= req_ren;
                        sext_q     <= req_sext;
                        size_q     <= req_size;
                        off_q      <= req_addr[2:0];
                        base_q     <= req_base;
                        wdata_q    <= req_wdata;
                        wmask_q    <= req_wmask;
                        two_beat_q <= req_two;
                        req_ready  <= 1'b0;
                        if (req_bad || req_null) begin
                            // No bus traffic: complete straight away.
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= req_bad;
                            resp_rdata <= '0;
                        end else begin
                            state     <= BEAT0;
                            mem_valid <= 1'b1;
                            mem_addr  <= req_base;
                            mem_wen   <= !req_ren;
                            mem_wdata <= req_ren ? '0 : req_lane_data[DATA_W-1:0];
                            mem_wstrb <= req_ren ? 8'h00 : req_lane_strb[7:0];
                        end
                    end
                end

                BEAT0, WAIT0: begin
                    if (beat_done) begin
                        if (two_beat_q) begin
                            // Second beat targets the next 8-byte word; the
                            // address wraps naturally at the top of memory.
                            state     <= BEAT1;
                            mem_valid <= 1'b1;
                            mem_addr  <= base_q + ADDR_W'(8);
                            mem_wdata <= ren_q ? '0 : q_lane_data[2*DATA_W-1:DATA_W];
                            mem_wstrb <= ren_q ? 8'h00 : q_lane_strb[15:8];
                        end else begin
                            state      <= DONE;
                            mem_valid  <= 1'b0;
                            mem_wen    <= 1'b0;
                            mem_wstrb  <= 8'h00;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= ren_q ? load_data : '0;
                        end
                    end else if (go_wait) begin
                        state     <= WAIT0;
                        mem_valid <= 1'b0;
                    end
                end

                BEAT1, WAIT1: begin
                    if (beat_done) begin
                        state      <= DONE;
                        mem_valid  <= 1'b0;
                        mem_wen    <= 1'b0;
                        mem_wstrb  <= 8'h00;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= ren_q ? load_data : '0;
                    end else if (go_wait) begin
                        state     <= WAIT1;
                        mem_valid <= 1'b0;
                    end
                end

                DONE: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end

                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    mem_valid <= 1'b0;
                end
            endcase

            if (cap0) begin
                buf0 <= mem_rdata;
            end
            if (cap1) begin
                buf1 <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22041207_lsu.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22041207_lsu
// Directed testbench for the load/store unit. The bus side is driven by hand
// in each scenario task so handshake timing is explicit; every expected value
// is a hand-computed constant.
// ---------------------------------------------------------------------------
module tb_ysyx_22041207_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wmask;
    logic        req_ren;
    logic [3:0]  req_rnum;
    logic        req_sext;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        mem_valid;
    logic        mem_ready;
    logic [63:0] mem_addr;
    logic        mem_wen;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;

    int tests_run    = 0;
    int tests_failed = 0;

    ysyx_22041207_lsu #(
        .ADDR_W(64),
        .DATA_W(64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .req_ren   (req_ren),
        .req_rnum  (req_rnum),
        .req_sext  (req_sext),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wen   (mem_wen),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rvalid(mem_rvalid),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge; outputs are sampled here
    // and inputs changed here, away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for exactly one edge. The caller ensures req_ready.
    task automatic send_req(input logic [63:0] addr, input logic [63:0] wdata,
                            input logic [7:0] wmask, input logic ren,
                            input logic [3:0] rnum, input logic sext);
        req_addr  = addr;
        req_wdata = wdata;
        req_wmask = wmask;
        req_ren   = ren;
        req_rnum  = rnum;
        req_sext  = sext;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        tests_run++;
        if (req_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_req_ready: got %b expected 1", req_ready);
        end
        tests_run++;
        if ({resp_valid, resp_err, resp_rdata} !== 66'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_resp: got v=%b e=%b d=%h expected all zero",
                     resp_valid, resp_err, resp_rdata);
        end
        tests_run++;
        if ({mem_valid, mem_wen, mem_addr, mem_wdata, mem_wstrb} !== 138'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_mem: got v=%b w=%b a=%h d=%h s=%h expected all zero",
                     mem_valid, mem_wen, mem_addr, mem_wdata, mem_wstrb);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_aligned_ld();
        mem_ready  = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata  = 64'h0;
        send_req(64'h80000010, 64'h0, 8'h00, 1'b1, 4'd8, 1'b1);
        tests_run++;
        if ({mem_valid, mem_wen, mem_addr, mem_wstrb, req_ready} !==
            {1'b1, 1'b0, 64'h80000010, 8'h00, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL ld_beat: got v=%b w=%b a=%h s=%h rdy=%b expected v=1 w=0 a=80000010 s=00 rdy=0",
                     mem_valid, mem_wen, mem_addr, mem_wstrb, req_ready);
        end
        step();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h8877665544332211;
        tests_run++;
        if ({mem_valid, resp_valid} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL ld_wait: got mem_valid=%b resp_valid=%b expected 0 0",
                     mem_valid, resp_valid);
        end
        step();
        mem_rvalid = 1'b0;
        tests_run++;
        if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 64'h8877665544332211}) begin
            tests_failed++;
            $display("[TB] FAIL ld_resp: got v=%b e=%b d=%h expected v=1 e=0 d=8877665544332211",
                     resp_valid, resp_err, resp_rdata);
        end
        step();
        tests_run++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL ld_pulse: got resp_valid=%b req_ready=%b expected 0 1",
                     resp_valid, req_ready);
        end
    endtask

    task automatic test_sign_zero_load();
        logic [63:0] exp_data [2];
        exp_data[0] = 64'hFFFFFFFFFFFFFFF0;
        exp_data[1] = 64'h00000000000000F0;
        for (int i = 0; i < 2; i++) begin
            mem_ready  = 1'b1;
            mem_rvalid = 1'b1;
            mem_rdata  = 64'h11223344F0556677;
            send_req(64'h80000003, 64'h0, 8'h00, 1'b1, 4'd1, (i == 0));
            tests_run++;
            if ({mem_valid, mem_addr} !== {1'b1, 64'h80000000}) begin
                tests_failed++;
                $display("[TB] FAIL lb_beat[%0d]: got v=%b a=%h expected v=1 a=80000000",
                         i, mem_valid, mem_addr);
            end
            step();
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            tests_run++;
            if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, exp_data[i]}) begin
                tests_failed++;
                $display("[TB] FAIL lb_resp[%0d]: got v=%b e=%b d=%h expected v=1 e=0 d=%h",
                         i, resp_valid, resp_err, resp_rdata, exp_data[i]);
            end
            step();
        end
    endtask

    task automatic test_split_lh_backpressure();
        logic [63:0] beat_addr [2];
        logic [63:0] beat_data [2];
        beat_addr[0] = 64'h80000000;
        beat_addr[1] = 64'h80000008;
        beat_data[0] = 64'h34AABBCCDDEEFF01;
        beat_data[1] = 64'h5566778899AABB92;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        send_req(64'h80000007, 64'h0, 8'h00, 1'b1, 4'd2, 1'b1);
        for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < 4; c++) begin
                if (c == 3) mem_ready = 1'b1;
                tests_run++;
                if ({mem_valid, mem_wen, mem_addr, mem_wstrb, req_ready} !==
                    {1'b1, 1'b0, beat_addr[b], 8'h00, 1'b0}) begin
                    tests_failed++;
                    $display("[TB] FAIL lh_hold[%0d.%0d]: got v=%b w=%b a=%h s=%h rdy=%b expected v=1 w=0 a=%h s=00 rdy=0",
                             b, c, mem_valid, mem_wen, mem_addr, mem_wstrb, req_ready, beat_addr[b]);
                end
                step();
            end
            mem_ready = 1'b0;
            for (int c = 0; c < 2; c++) begin
                tests_run++;
                if ({mem_valid, resp_valid} !== 2'b00) begin
                    tests_failed++;
                    $display("[TB] FAIL lh_wait[%0d.%0d]: got mem_valid=%b resp_valid=%b expected 0 0",
                             b, c, mem_valid, resp_valid);
                end
                step();
            end
            mem_rvalid = 1'b1;
            mem_rdata  = beat_data[b];
            step();
            mem_rvalid = 1'b0;
        end
        tests_run++;
        if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 64'hFFFFFFFFFFFF9234}) begin
            tests_failed++;
            $display("[TB] FAIL lh_resp: got v=%b e=%b d=%h expected v=1 e=0 d=ffffffffffff9234",
                     resp_valid, resp_err, resp_rdata);
        end
        step();
    endtask

    task automatic test_null_request();
        mem_ready  = 1'b1;
        mem_rvalid = 1'b0;
        send_req(64'h80000100, 64'hDEADBEEF, 8'h00, 1'b0, 4'd0, 1'b0);
        tests_run++;
        if ({resp_valid, resp_err, resp_rdata, mem_valid} !== {1'b1, 1'b0, 64'h0, 1'b0}) begin
            tests_failed++;
            $display("[TB] FAIL null_resp: got v=%b e=%b d=%h mem_valid=%b expected v=1 e=0 d=0 mem_valid=0",
                     resp_valid, resp_err, resp_rdata, mem_valid);
        end
        step();
        mem_ready = 1'b0;
        tests_run++;
        if ({resp_valid, mem_valid, req_ready} !== 3'b001) begin
            tests_failed++;
            $display("[TB] FAIL null_after: got resp_valid=%b mem_valid=%b req_ready=%b expected 0 0 1",
                     resp_valid, mem_valid, req_ready);
        end
    endtask

    task automatic test_malformed();
        logic       ren  [3];
        logic [7:0] mask [3];
        logic [3:0] rnum [3];
        ren[0] = 1'b1; mask[0] = 8'h01; rnum[0] = 4'd1;
        ren[1] = 1'b1; mask[1] = 8'h00; rnum[1] = 4'd3;
        ren[2] = 1'b0; mask[2] = 8'h05; rnum[2] = 4'd0;
        mem_ready  = 1'b1;
        mem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_req(64'h80000200, 64'h0123, mask[i], ren[i], rnum[i], 1'b0);
            tests_run++;
            if ({resp_valid, resp_err, mem_valid} !== 3'b110) begin
                tests_failed++;
                $display("[TB] FAIL bad_resp[%0d]: got resp_valid=%b resp_err=%b mem_valid=%b expected 1 1 0",
                         i, resp_valid, resp_err, mem_valid);
            end
            step();
            tests_run++;
            if ({resp_valid, mem_valid, req_ready} !== 3'b001) begin
                tests_failed++;
                $display("[TB] FAIL bad_after[%0d]: got resp_valid=%b mem_valid=%b req_ready=%b expected 0 0 1",
                         i, resp_valid, mem_valid, req_ready);
            end
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_split_store();
        logic [63:0] addr  [2];
        logic [63:0] wdata [2];
        logic [63:0] a0 [2];
        logic [63:0] d0 [2];
        logic [63:0] a1 [2];
        logic [63:0] d1 [2];
        addr[0] = 64'h80000006;         wdata[0] = 64'hAABBCCDD;
        a0[0]   = 64'h80000000;         d0[0]    = 64'hCCDD000000000000;
        a1[0]   = 64'h80000008;         d1[0]    = 64'h000000000000AABB;
        addr[1] = 64'hFFFFFFFFFFFFFFFE; wdata[1] = 64'h11223344;
        a0[1]   = 64'hFFFFFFFFFFFFFFF8; d0[1]    = 64'h3344000000000000;
        a1[1]   = 64'h0000000000000000; d1[1]    = 64'h0000000000001122;
        mem_ready  = 1'b1;
        mem_rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            send_req(addr[i], wdata[i], 8'h0F, 1'b0, 4'd0, 1'b0);
            tests_run++;
            if ({mem_valid, mem_wen, mem_addr, mem_wstrb, mem_wdata} !==
                {1'b1, 1'b1, a0[i], 8'hC0, d0[i]}) begin
                tests_failed++;
                $display("[TB] FAIL sw_beat0[%0d]: got v=%b w=%b a=%h s=%h d=%h expected v=1 w=1 a=%h s=c0 d=%h",
                         i, mem_valid, mem_wen, mem_addr, mem_wstrb, mem_wdata, a0[i], d0[i]);
            end
            step();
            tests_run++;
            if ({mem_valid, mem_wen, mem_addr, mem_wstrb, mem_wdata} !==
                {1'b1, 1'b1, a1[i], 8'h03, d1[i]}) begin
                tests_failed++;
                $display("[TB] FAIL sw_beat1[%0d]: got v=%b w=%b a=%h s=%h d=%h expected v=1 w=1 a=%h s=03 d=%h",
                         i, mem_valid, mem_wen, mem_addr, mem_wstrb, mem_wdata, a1[i], d1[i]);
            end
            step();
            tests_run++;
            if ({resp_valid, resp_err, resp_rdata, mem_valid} !== {1'b1, 1'b0, 64'h0, 1'b0}) begin
                tests_failed++;
                $display("[TB] FAIL sw_resp[%0d]: got v=%b e=%b d=%h mem_valid=%b expected v=1 e=0 d=0 mem_valid=0",
                         i, resp_valid, resp_err, resp_rdata, mem_valid);
            end
            step();
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        mem_ready  = 1'b1;
        mem_rvalid = 1'b0;
        send_req(64'h80000020, 64'h0123456789ABCDEF, 8'hFF, 1'b0, 4'd0, 1'b0);
        tests_run++;
        if ({mem_valid, mem_wen, mem_addr, mem_wstrb, mem_wdata} !==
            {1'b1, 1'b1, 64'h80000020, 8'hFF, 64'h0123456789ABCDEF}) begin
            tests_failed++;
            $display("[TB] FAIL sd_beat: got v=%b w=%b a=%h s=%h d=%h expected v=1 w=1 a=80000020 s=ff d=0123456789abcdef",
                     mem_valid, mem_wen, mem_addr, mem_wstrb, mem_wdata);
        end
        step();
        tests_run++;
        if ({resp_valid, req_ready} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL sd_latency: got resp_valid=%b req_ready=%b expected 1 0",
                     resp_valid, req_ready);
        end
        step();
        tests_run++;
        if ({resp_valid, req_ready} !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL sd_ready_again: got resp_valid=%b req_ready=%b expected 0 1",
                     resp_valid, req_ready);
        end
        send_req(64'h80000025, 64'h5A, 8'h01, 1'b0, 4'd0, 1'b0);
        tests_run++;
        if ({mem_valid, mem_wen, mem_addr, mem_wstrb, mem_wdata} !==
            {1'b1, 1'b1, 64'h80000020, 8'h20, 64'h00005A0000000000}) begin
            tests_failed++;
            $display("[TB] FAIL sb_beat: got v=%b w=%b a=%h s=%h d=%h expected v=1 w=1 a=80000020 s=20 d=00005a0000000000",
                     mem_valid, mem_wen, mem_addr, mem_wstrb, mem_wdata);
        end
        step();
        tests_run++;
        if ({resp_valid, resp_err} !== 2'b10) begin
            tests_failed++;
            $display("[TB] FAIL sb_resp: got resp_valid=%b resp_err=%b expected 1 0",
                     resp_valid, resp_err);
        end
        mem_ready = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_op();
        // Leave a non-zero result behind so the reset clear is observable.
        mem_ready  = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hCAFEF00D12345678;
        send_req(64'h80000040, 64'h0, 8'h00, 1'b1, 4'd8, 1'b0);
        step();
        tests_run++;
        if ({resp_valid, resp_rdata} !== {1'b1, 64'hCAFEF00D12345678}) begin
            tests_failed++;
            $display("[TB] FAIL pre_rst_load: got v=%b d=%h expected v=1 d=cafef00d12345678",
                     resp_valid, resp_rdata);
        end
        mem_rvalid = 1'b0;
        step();
        send_req(64'h80000040, 64'h0, 8'h00, 1'b1, 4'd8, 1'b0);
        step();
        mem_ready = 1'b0;
        tests_run++;
        if ({mem_valid, req_ready} !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL rst_in_wait: got mem_valid=%b req_ready=%b expected 0 0",
                     mem_valid, req_ready);
        end
        rst = 1'b1;
        #1;
        tests_run++;
        if ({req_ready, resp_valid, resp_err, resp_rdata, mem_valid, mem_wen,
             mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 204'd0}) begin
            tests_failed++;
            $display("[TB] FAIL rst_async: got rdy=%b rv=%b re=%b rd=%h mv=%b mw=%b ma=%h md=%h ms=%h expected rdy=1 others 0",
                     req_ready, resp_valid, resp_err, resp_rdata, mem_valid, mem_wen,
                     mem_addr, mem_wdata, mem_wstrb);
        end
        #1;
        rst = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h1111111111111111;
        step();
        mem_rvalid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tests_run++;
            if ({resp_valid, mem_valid, req_ready} !== 3'b001) begin
                tests_failed++;
                $display("[TB] FAIL rst_late_rvalid[%0d]: got resp_valid=%b mem_valid=%b req_ready=%b expected 0 0 1",
                         c, resp_valid, mem_valid, req_ready);
            end
            step();
        end
        mem_ready  = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h89ABCDEF00000000;
        send_req(64'h80000044, 64'h0, 8'h00, 1'b1, 4'd4, 1'b0);
        step();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        tests_run++;
        if ({resp_valid, resp_err, resp_rdata} !== {1'b1, 1'b0, 64'h0000000089ABCDEF}) begin
            tests_failed++;
            $display("[TB] FAIL post_rst_lwu: got v=%b e=%b d=%h expected v=1 e=0 d=0000000089abcdef",
                     resp_valid, resp_err, resp_rdata);
        end
        step();
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_addr   = 64'h0;
        req_wdata  = 64'h0;
        req_wmask  = 8'h00;
        req_ren    = 1'b0;
        req_rnum   = 4'd0;
        req_sext   = 1'b0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 64'h0;

        test_reset();
        test_aligned_ld();
        test_sign_zero_load();
        test_split_lh_backpressure();
        test_null_request();
        test_malformed();
        test_split_store();
        test_back_to_back();
        test_reset_mid_op();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached before the summary");
        $fatal(1, "[TB] simulation time limit");
    end

endmodule
